// File: rtl/aq_djpeg_pixout_if.sv
// Pixel stream bundle for the JPEG pixel output stage: converter-side pixel
// input with InFull backpressure, and the valid/ready output word stream.
interface aq_djpeg_pixout_if #(
  parameter int COORD_W = 16
);
  logic               InEnable;
  logic [COORD_W-1:0] InPixelX;
  logic [COORD_W-1:0] InPixelY;
  logic [7:0]         InR;
  logic [7:0]         InG;
  logic [7:0]         InB;
  logic               InFull;
  logic               OutValid;
  logic               OutReady;
  logic [23:0]        OutData;
  logic               OutSof;
  logic               OutEol;

  modport slave (
    input  InEnable, InPixelX, InPixelY, InR, InG, InB, OutReady,
    output InFull, OutValid, OutData, OutSof, OutEol
  );

  modport master (
    output InEnable, InPixelX, InPixelY, InR, InG, InB, OutReady,
    input  InFull, OutValid, OutData, OutSof, OutEol
  );
endinterface

// File: rtl/aq_djpeg_pixout.sv
// JPEG pixel output stage: crops to image size, buffers in a FWFT FIFO with SOF/EOL tags.
// Optional AQ_DJPEG_PIXOUT_DROPCNT_EN builds a saturating overflow-drop counter.
module aq_djpeg_pixout #(
  parameter int FIFO_DEPTH  = 16,
  parameter int FULL_MARGIN = 4,
  parameter int COORD_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ProcessInit,
  input  logic [COORD_W-1:0]          InWidth,
  input  logic [COORD_W-1:0]          InHeight,
  aq_djpeg_pixout_if.slave            px,
  output logic [$clog2(FIFO_DEPTH):0] FifoLevel,
  output logic                        Overflow,
  output logic [31:0]                 DropCount
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] THR_C   = (AW+1)'(FIFO_DEPTH - FULL_MARGIN);

  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_infull, r_ovf;
  logic [25:0]   r_mem [FIFO_DEPTH];

  logic          w_accept, w_full, w_pop, w_wr, w_drop, w_sof, w_eol, w_valid;
  logic [AW:0]   w_count_nxt;
  logic [25:0]   w_wdata, w_head;

  assign w_accept = px.InEnable && (px.InPixelX < InWidth) && (px.InPixelY < InHeight) && !ProcessInit;
  assign w_full   = (r_count == DEPTH_C);
  assign w_pop    = (r_count != '0) && px.OutReady;
  // A full FIFO still takes the write when the head leaves in the same cycle.
  assign w_wr     = w_accept && (!w_full || w_pop);
  assign w_drop   = w_accept && w_full && !w_pop;

  assign w_count_nxt = r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
  assign w_sof   = (px.InPixelX == '0) && (px.InPixelY == '0);
  assign w_eol   = (px.InPixelX == InWidth - COORD_W'(1));
  assign w_wdata = {w_sof, w_eol, px.InR, px.InG, px.InB};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_infull <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (ProcessInit) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_infull <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr)   r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_drop) r_ovf  <= 1'b1;
      r_count  <= w_count_nxt;
      r_infull <= (w_count_nxt >= THR_C);
    end
  end

  // Storage needs no reset: stale entries are never visible while count is 0.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_wdata;
  end

  assign w_head  = r_mem[r_rptr];
  assign w_valid = (r_count != '0);

  assign px.OutValid = w_valid;
  assign px.OutData  = w_valid ? w_head[23:0] : 24'd0;
  assign px.OutSof   = w_valid & w_head[25];
  assign px.OutEol   = w_valid & w_head[24];
  assign px.InFull   = r_infull;
  assign FifoLevel   = r_count;
  assign Overflow    = r_ovf;

`ifdef AQ_DJPEG_PIXOUT_DROPCNT_EN
  logic [31:0] r_dropcnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              r_dropcnt <= '0;
    else if (ProcessInit)                  r_dropcnt <= '0;
    else if (w_drop && (r_dropcnt != '1))  r_dropcnt <= r_dropcnt + 32'd1;
  end
  assign DropCount = r_dropcnt;
`else
  assign DropCount = 32'd0;
`endif
endmodule

// File: tb/tb_aq_djpeg_pixout.sv
// Self-checking bench for aq_djpeg_pixout: queue-based reference model plus directed and random scenarios.
module tb_aq_djpeg_pixout;
  localparam int DEPTH = 16, MARGIN = 4, CW = 16;

  logic        clk = 1'b0, rst = 1'b0, ProcessInit = 1'b0;
  logic [15:0] InWidth = 16'd10, InHeight = 16'd4;
  logic [4:0]  FifoLevel;
  logic        Overflow;
  logic [31:0] DropCount;

  aq_djpeg_pixout_if #(.COORD_W(CW)) px();

  aq_djpeg_pixout #(.FIFO_DEPTH(DEPTH), .FULL_MARGIN(MARGIN), .COORD_W(CW)) dut (
    .clk(clk), .rst(rst), .ProcessInit(ProcessInit), .InWidth(InWidth), .InHeight(InHeight),
    .px(px), .FifoLevel(FifoLevel), .Overflow(Overflow), .DropCount(DropCount)
  );

  always #5 clk = ~clk;

  int          n_pass = 0, n_total = 0;
  logic [25:0] mq[$], exp_q[$], got_q[$];
  logic        m_ovf = 1'b0;
  int          m_drop = 0;
  logic [7:0]  salt;

  function automatic logic [23:0] pix(input int x, input int y);
    return {8'(x), 8'(y), 8'(x * 3 + y * 5) ^ salt};
  endfunction

  function automatic logic [31:0] exp_drop();
`ifdef AQ_DJPEG_PIXOUT_DROPCNT_EN
    return 32'(m_drop);
`else
    return 32'd0;
`endif
  endfunction

  task automatic drive(input logic en, input int x, input int y, input logic [23:0] rgb);
    px.InEnable = en; px.InPixelX = 16'(x); px.InPixelY = 16'(y);
    {px.InR, px.InG, px.InB} = rgb;
  endtask

  // One clock: record DUT pops, advance the reference queue, land at posedge+1.
  task automatic cycle();
    logic pop, acc;
    logic [25:0] ent;
    @(negedge clk);
    if (px.OutValid && px.OutReady) got_q.push_back({px.OutSof, px.OutEol, px.OutData});
    if (ProcessInit) begin
      mq.delete(); m_ovf = 1'b0; m_drop = 0;
    end else begin
      pop = (mq.size() != 0) && px.OutReady;
      acc = px.InEnable && (int'(px.InPixelX) < int'(InWidth)) && (int'(px.InPixelY) < int'(InHeight));
      ent = {(px.InPixelX == 0 && px.InPixelY == 0), (int'(px.InPixelX) == int'(InWidth) - 1),
             px.InR, px.InG, px.InB};
      if (pop) exp_q.push_back(mq.pop_front());
      if (acc) begin
        if (mq.size() < DEPTH) mq.push_back(ent);
        else begin m_ovf = 1'b1; m_drop++; end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic flush();
    drive(1'b0, 0, 0, 24'd0);
    px.OutReady = 1'b0; ProcessInit = 1'b1;
    cycle();
    ProcessInit = 1'b0;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    drive(1'b0, 0, 0, 24'd0); px.OutReady = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_total++; if (px.OutValid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", px.OutValid); else n_pass++;
    n_total++; if (px.InFull !== 1'b0) $display("FAIL reset_infull: got %0b want 0", px.InFull); else n_pass++;
    n_total++; if (FifoLevel !== 5'd0) $display("FAIL reset_level: got %0d want 0", FifoLevel); else n_pass++;
    n_total++; if (Overflow !== 1'b0) $display("FAIL reset_ovf: got %0b want 0", Overflow); else n_pass++;
    n_total++; if (DropCount !== 32'd0) $display("FAIL reset_drop: got %0d want 0", DropCount); else n_pass++;
    n_total++; if ({px.OutSof, px.OutEol, px.OutData} !== 26'd0)
      $display("FAIL reset_data: got %0h want 0", {px.OutSof, px.OutEol, px.OutData}); else n_pass++;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_crop();
    logic [25:0] want[$];
    int nsof;
    InWidth = 16'd10; InHeight = 16'd4;
    flush(); px.OutReady = 1'b1;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) begin drive(1'b1, x, y, pix(x, y)); cycle(); end
    drive(1'b0, 0, 0, 24'd0);
    repeat (4) cycle();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 10; x++) want.push_back({(x == 0 && y == 0), (x == 9), pix(x, y)});
    n_total++; if (got_q.size() !== 40) $display("FAIL crop_count: got %0d want 40", got_q.size()); else n_pass++;
    nsof = 0;
    foreach (got_q[i]) nsof += int'(got_q[i][25]);
    n_total++; if (nsof !== 1) $display("FAIL crop_sof_count: got %0d want 1", nsof); else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      n_total++;
      if (got_q.size() < 10 * k || got_q[10 * k - 1][24] !== 1'b1)
        $display("FAIL crop_eol_word%0d: got size %0d want eol set", 10 * k, got_q.size());
      else n_pass++;
    end
    for (int i = 0; i < 40 && i < got_q.size(); i++) begin
      n_total++; if (got_q[i] !== want[i]) $display("FAIL crop_word%0d: got %0h want %0h", i, got_q[i], want[i]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    InWidth = 16'd64; InHeight = 16'd64;
    flush();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, i, 1, pix(i, 1)); cycle();
      if (i == 10) begin
        n_total++; if (px.InFull !== 1'b0) $display("FAIL bp_infull_at11: got %0b want 0", px.InFull); else n_pass++;
      end
    end
    n_total++; if (px.InFull !== 1'b1) $display("FAIL bp_infull_at12: got %0b want 1", px.InFull); else n_pass++;
    n_total++; if (FifoLevel !== 5'd12) $display("FAIL bp_level12: got %0d want 12", FifoLevel); else n_pass++;
    n_total++; if (px.OutValid !== 1'b1) $display("FAIL bp_valid: got %0b want 1", px.OutValid); else n_pass++;
    for (int i = 12; i < 16; i++) begin drive(1'b1, i, 1, pix(i, 1)); cycle(); end
    n_total++; if (FifoLevel !== 5'd16) $display("FAIL bp_level16: got %0d want 16", FifoLevel); else n_pass++;
    n_total++; if (Overflow !== 1'b0) $display("FAIL bp_ovf: got %0b want 0", Overflow); else n_pass++;
  endtask

  task automatic test_overflow();
    for (int i = 16; i < 19; i++) begin drive(1'b1, i, 1, pix(i, 1)); cycle(); end
    n_total++; if (Overflow !== 1'b1) $display("FAIL ovf_flag: got %0b want 1", Overflow); else n_pass++;
    n_total++; if (FifoLevel !== 5'd16) $display("FAIL ovf_level: got %0d want 16", FifoLevel); else n_pass++;
    n_total++; if (DropCount !== exp_drop()) $display("FAIL ovf_dropcnt: got %0d want %0d", DropCount, exp_drop()); else n_pass++;
    drive(1'b0, 0, 0, 24'd0); px.OutReady = 1'b1;
    got_q.delete();
    repeat (18) cycle();
    n_total++; if (got_q.size() !== 16) $display("FAIL ovf_drain_count: got %0d want 16", got_q.size()); else n_pass++;
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      n_total++; if (got_q[i][23:0] !== pix(i, 1)) $display("FAIL ovf_drain%0d: got %0h want %0h", i, got_q[i][23:0], pix(i, 1)); else n_pass++;
    end
    n_total++; if (Overflow !== 1'b1) $display("FAIL ovf_sticky: got %0b want 1", Overflow); else n_pass++;
  endtask

  task automatic test_full_pop();
    flush();
    for (int i = 0; i < 16; i++) begin drive(1'b1, i, 2, pix(i, 2)); cycle(); end
    got_q.delete();
    drive(1'b1, 20, 2, pix(20, 2)); px.OutReady = 1'b1;
    cycle();
    n_total++; if (FifoLevel !== 5'd16) $display("FAIL fp_level: got %0d want 16", FifoLevel); else n_pass++;
    n_total++; if (Overflow !== 1'b0) $display("FAIL fp_ovf: got %0b want 0", Overflow); else n_pass++;
    drive(1'b0, 0, 0, 24'd0);
    repeat (18) cycle();
    n_total++; if (got_q.size() !== 17) $display("FAIL fp_count: got %0d want 17", got_q.size()); else n_pass++;
    if (got_q.size() == 17) begin
      n_total++; if (got_q[0][23:0] !== pix(0, 2)) $display("FAIL fp_first: got %0h want %0h", got_q[0][23:0], pix(0, 2)); else n_pass++;
      n_total++; if (got_q[16][23:0] !== pix(20, 2)) $display("FAIL fp_last: got %0h want %0h", got_q[16][23:0], pix(20, 2)); else n_pass++;
    end
  endtask

  task automatic test_flush();
    flush();
    for (int i = 0; i < 17; i++) begin drive(1'b1, i, 3, pix(i, 3)); cycle(); end
    drive(1'b0, 0, 0, 24'd0); px.OutReady = 1'b1;
    repeat (9) cycle();
    px.OutReady = 1'b0;
    n_total++; if (FifoLevel !== 5'd7) $display("FAIL fl_pre_level: got %0d want 7", FifoLevel); else n_pass++;
    n_total++; if (Overflow !== 1'b1) $display("FAIL fl_pre_ovf: got %0b want 1", Overflow); else n_pass++;
    ProcessInit = 1'b1; cycle(); ProcessInit = 1'b0;
    n_total++; if (px.OutValid !== 1'b0) $display("FAIL fl_valid: got %0b want 0", px.OutValid); else n_pass++;
    n_total++; if (FifoLevel !== 5'd0) $display("FAIL fl_level: got %0d want 0", FifoLevel); else n_pass++;
    n_total++; if (Overflow !== 1'b0) $display("FAIL fl_ovf: got %0b want 0", Overflow); else n_pass++;
    n_total++; if (DropCount !== 32'd0) $display("FAIL fl_drop: got %0d want 0", DropCount); else n_pass++;
    n_total++; if (px.InFull !== 1'b0) $display("FAIL fl_infull: got %0b want 0", px.InFull); else n_pass++;
    drive(1'b1, 0, 0, pix(0, 0)); cycle(); drive(1'b0, 0, 0, 24'd0);
    n_total++; if (px.OutValid !== 1'b1) $display("FAIL fl_new_valid: got %0b want 1", px.OutValid); else n_pass++;
    n_total++; if (px.OutSof !== 1'b1) $display("FAIL fl_new_sof: got %0b want 1", px.OutSof); else n_pass++;
    n_total++; if (px.OutData !== pix(0, 0)) $display("FAIL fl_new_data: got %0h want %0h", px.OutData, pix(0, 0)); else n_pass++;
  endtask

  task automatic test_async_reset();
    flush();
    for (int i = 0; i < 17; i++) begin drive(1'b1, i, 5, pix(i, 5)); cycle(); end
    drive(1'b0, 0, 0, 24'd0);
    #2 rst = 1'b0;
    #1;
    n_total++; if (px.OutValid !== 1'b0) $display("FAIL ar_valid: got %0b want 0", px.OutValid); else n_pass++;
    n_total++; if (px.InFull !== 1'b0) $display("FAIL ar_infull: got %0b want 0", px.InFull); else n_pass++;
    n_total++; if (FifoLevel !== 5'd0) $display("FAIL ar_level: got %0d want 0", FifoLevel); else n_pass++;
    n_total++; if (Overflow !== 1'b0) $display("FAIL ar_ovf: got %0b want 0", Overflow); else n_pass++;
    n_total++; if (DropCount !== 32'd0) $display("FAIL ar_drop: got %0d want 0", DropCount); else n_pass++;
    n_total++; if ({px.OutSof, px.OutEol, px.OutData} !== 26'd0)
      $display("FAIL ar_data: got %0h want 0", {px.OutSof, px.OutEol, px.OutData}); else n_pass++;
    mq.delete(); m_ovf = 1'b0; m_drop = 0; got_q.delete(); exp_q.delete();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    px.OutReady = 1'b1;
    repeat (4) cycle();
    n_total++; if (px.OutValid !== 1'b0 || got_q.size() !== 0)
      $display("FAIL ar_post_idle: got valid %0b words %0d want 0 0", px.OutValid, got_q.size()); else n_pass++;
  endtask

  task automatic test_random();
    int w, h, x, y, bad;
    w = $urandom_range(1, 12); h = $urandom_range(1, 6);
    InWidth = 16'(w); InHeight = 16'(h);
    flush();
    bad = 0;
    for (int c = 0; c < 600; c++) begin
      x = ($urandom % 10 == 0) ? 65535 - int'($urandom_range(0, 3)) : int'($urandom_range(0, w + 3));
      y = int'($urandom_range(0, h + 2));
      drive(($urandom % 4) != 0, x, y, 24'($urandom));
      px.OutReady = ($urandom % 100) < ((c / 100) % 2 == 0 ? 85 : 25);
      cycle();
      n_total++; if (FifoLevel !== 5'(mq.size())) $display("FAIL rnd_level c%0d: got %0d want %0d", c, FifoLevel, mq.size()); else n_pass++;
      n_total++; if (px.InFull !== (mq.size() >= DEPTH - MARGIN)) $display("FAIL rnd_infull c%0d: got %0b want %0b", c, px.InFull, mq.size() >= DEPTH - MARGIN); else n_pass++;
      n_total++; if (Overflow !== m_ovf) $display("FAIL rnd_ovf c%0d: got %0b want %0b", c, Overflow, m_ovf); else n_pass++;
      if (mq.size() != 0) begin
        n_total++; if ({px.OutSof, px.OutEol, px.OutData} !== mq[0])
          $display("FAIL rnd_head c%0d: got %0h want %0h", c, {px.OutSof, px.OutEol, px.OutData}, mq[0]); else n_pass++;
      end
    end
    n_total++; if (DropCount !== exp_drop()) $display("FAIL rnd_dropcnt: got %0d want %0d", DropCount, exp_drop()); else n_pass++;
    drive(1'b0, 0, 0, 24'd0); px.OutReady = 1'b1;
    repeat (DEPTH + 2) cycle();
    n_total++; if (got_q.size() !== exp_q.size()) $display("FAIL rnd_words: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
    n_total++; if (bad !== 0) $display("FAIL rnd_stream: got %0d differing words want 0", bad); else n_pass++;
  endtask

  initial begin
    salt = 8'($urandom);
    drive(1'b0, 0, 0, 24'd0); px.OutReady = 1'b0;
    test_reset();
    test_crop();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
